// File: rtl/executs_muldiv.sv
// executs_muldiv
//   Iterative multiply/divide unit that sits beside the single-cycle execute ALU.
//   It owns the architectural HI/LO registers and serves mult, multu, div, divu,
//   mthi, mtlo, mfhi and mflo. An iterative operation takes WIDTH cycles in CALC,
//   then one FIX cycle for sign correction and the HI/LO write, then one DONE cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | accepts Md_start; mthi/mtlo are written here directly
//   CALC  | one multiplier bit / quotient bit per cycle, WIDTH cycles
//   FIX   | sign correction, HI/LO written at the end of this cycle
//   DONE  | Md_done pulse, HI/LO hold the new result
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   Md_start, Md_op     request pulse and operation select (sampled in IDLE only)
//   Read_data_1/2       rs / rt operands
//   Md_sel              read select: 1 = HI, 0 = LO
//   Md_busy, Md_done    stall request and result-ready pulse
//   Md_result           combinational HI/LO read
//   Hi_out, Lo_out      HI and LO registers

module executs_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Md_start,
    input  logic [2:0]       Md_op,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic             Md_sel,
    output logic             Md_busy,
    output logic             Md_done,
    output logic [WIDTH-1:0] Md_result,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 div0_q, div0_d;
    logic                 neg_ab_q, neg_ab_d;
    logic                 neg_a_q, neg_a_d;

    // operand conditioning: signed ops (mult, div) have Md_op[0] = 0
    logic                 sgn_a, sgn_b;
    logic [WIDTH-1:0]     mag_a, mag_b;

    assign sgn_a = ~Md_op[0] & Read_data_1[WIDTH-1];
    assign sgn_b = ~Md_op[0] & Read_data_2[WIDTH-1];
    // the most-negative value negates to itself, which read unsigned is its magnitude
    assign mag_a = sgn_a ? -Read_data_1 : Read_data_1;
    assign mag_b = sgn_b ? -Read_data_2 : Read_data_2;

    // shift-add multiply: acc = {partial product high, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // restoring divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;

    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    // when div_ge holds the true difference is below the divisor, so WIDTH bits suffice
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // sign correction applied in FIX
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign prod_fix = neg_ab_q ? -acc_q : acc_q;
    assign quo_fix  = neg_ab_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Md_start && !Md_op[2]) state_d = S_CALC;
            S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        Md_busy   = (state_q != S_IDLE);
        Md_done   = (state_q == S_DONE);
        Md_result = Md_sel ? hi_q : lo_q;
        Hi_out    = hi_q;
        Lo_out    = lo_q;
    end

    // datapath next-state
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_ab_d = neg_ab_q;
        neg_a_d  = neg_a_q;
        case (state_q)
            S_IDLE: begin
                if (Md_start) begin
                    case (Md_op)
                        3'b100: hi_d = Read_data_1;
                        3'b101: lo_d = Read_data_1;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = Md_op[1];
                            neg_ab_d = sgn_a ^ sgn_b;
                            neg_a_d  = sgn_a;
                            div0_d   = (Read_data_2 == '0);
                            raw_a_d  = Read_data_1;
                            // divide iterates against the divisor, multiply adds the multiplicand
                            opnd_d   = Md_op[1] ? mag_b : mag_a;
                            acc_d    = {{WIDTH{1'b0}}, (Md_op[1] ? mag_a : mag_b)};
                            cnt_d    = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            raw_a_q  <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_ab_q <= 1'b0;
            neg_a_q  <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            raw_a_q  <= raw_a_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_ab_q <= neg_ab_d;
            neg_a_q  <= neg_a_d;
        end
    end

endmodule

// File: tb/tb_executs_muldiv.sv
module tb_executs_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start, md_sel, md_busy, md_done;
    logic [2:0]  md_op;
    logic [31:0] rd1, rd2, md_result, hi_out, lo_out;

    logic        start8, sel8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8, hi8, lo8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_hi[$];
    logic [31:0] q_lo[$];
    logic [31:0] cur_hi, cur_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    executs_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clk), .reset(rst), .Md_start(md_start), .Md_op(md_op),
        .Read_data_1(rd1), .Read_data_2(rd2), .Md_sel(md_sel),
        .Md_busy(md_busy), .Md_done(md_done), .Md_result(md_result),
        .Hi_out(hi_out), .Lo_out(lo_out)
    );

    executs_muldiv #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clock(clk), .reset(rst), .Md_start(start8), .Md_op(op8),
        .Read_data_1(a8), .Read_data_2(b8), .Md_sel(sel8),
        .Md_busy(busy8), .Md_done(done8), .Md_result(res8),
        .Hi_out(hi8), .Lo_out(lo8)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // reference result {hi, lo} for a 32-bit mult/div operation
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0] r;
        case (op)
            3'b000:  r = 64'(sa * sb);
            3'b001:  r = ua * ub;
            3'b010:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
        endcase
        return r;
    endfunction

    // issue one iterative op; optionally pulse a competing Md_start at cycle 'poke'
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int poke, input string nm);
        int cyc;
        int busy_n;
        logic [31:0] xh, xl;
        @(posedge clk); #1;
        md_op = op; rd1 = a; rd2 = b; md_start = 1'b1;
        q_hi.push_back(ehi);
        q_lo.push_back(elo);
        @(posedge clk); #1;
        md_start = 1'b0;
        cyc = 1;
        busy_n = 0;
        while (cyc < 80) begin
            if (md_busy) busy_n++;
            if (cyc == 3) begin
                check({nm, " hi held while busy"}, 64'(hi_out), 64'(cur_hi));
                check({nm, " lo held while busy"}, 64'(lo_out), 64'(cur_lo));
            end
            if (md_done) break;
            if (cyc == poke) begin
                md_start = 1'b1; md_op = 3'b000; rd1 = 32'h7; rd2 = 32'h9;
            end else begin
                md_start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        md_start = 1'b0;
        check({nm, " latency"}, 64'(cyc), 64'd34);
        check({nm, " busy cycles"}, 64'(busy_n), 64'd34);
        xh = q_hi.pop_front();
        xl = q_lo.pop_front();
        check({nm, " hi"}, 64'(hi_out), 64'(xh));
        check({nm, " lo"}, 64'(lo_out), 64'(xl));
        check({nm, " result(sel=0)"}, 64'(md_result), 64'(xl));
        @(posedge clk); #1;
        check({nm, " done single pulse"}, 64'(md_done), 64'd0);
        check({nm, " idle after done"}, 64'(md_busy), 64'd0);
        cur_hi = xh;
        cur_lo = xl;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo, input string nm);
        int cyc;
        @(posedge clk); #1;
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'd10);
        check({nm, " hi"}, 64'(hi8), 64'(ehi));
        check({nm, " lo"}, 64'(lo8), 64'(elo));
        sel8 = 1'b1; #1;
        check({nm, " result(sel=1)"}, 64'(res8), 64'(ehi));
        sel8 = 1'b0;
    endtask

    initial begin
        logic        seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] m;

        vecs[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'b011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[4]  = '{3'b011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{3'b010, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[9]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[10] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        rst = 1'b1; md_start = 1'b0; md_op = 3'b000; rd1 = '0; rd2 = '0; md_sel = 1'b0;
        start8 = 1'b0; op8 = 3'b000; a8 = '0; b8 = '0; sel8 = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        check("reset busy", 64'(md_busy), 64'd0);
        check("reset done", 64'(md_done), 64'd0);
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset lo", 64'(lo_out), 64'd0);

        // mtlo then mthi in consecutive idle cycles
        @(posedge clk); #1;
        md_start = 1'b1; md_op = 3'b101; rd1 = 32'h1234;
        @(posedge clk); #1;
        check("mtlo busy", 64'(md_busy), 64'd0);
        check("mtlo done", 64'(md_done), 64'd0);
        md_op = 3'b100; rd1 = 32'hABCD;
        @(posedge clk); #1;
        md_start = 1'b0;
        check("mthi busy", 64'(md_busy), 64'd0);
        check("mthi done", 64'(md_done), 64'd0);
        check("mtlo lo", 64'(lo_out), 64'h1234);
        check("mthi hi", 64'(hi_out), 64'hABCD);
        for (int i = 0; i < 4; i++) begin
            md_sel = i[0]; #1;
            check("md_sel read", 64'(md_result), (i[0] ? 64'hABCD : 64'h1234));
        end
        md_sel = 1'b0;
        cur_hi = 32'hABCD;
        cur_lo = 32'h1234;

        // reserved op leaves everything untouched
        @(posedge clk); #1;
        md_start = 1'b1; md_op = 3'b110; rd1 = 32'h5555;
        @(posedge clk); #1;
        md_start = 1'b0;
        check("reserved busy", 64'(md_busy), 64'd0);
        check("reserved hi", 64'(hi_out), 64'hABCD);
        check("reserved lo", 64'(lo_out), 64'h1234);

        for (int i = 0; i < NV; i++)
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                  (i == 2) ? 5 : 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i[0]) rb = rb >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd3;
            m = model(rop, ra, rb);
            run32(rop, ra, rb, m[63:32], m[31:0], 0, $sformatf("rand%0d", i));
        end

        // reset at cycle 10 of a divide aborts it
        @(posedge clk); #1;
        md_op = 3'b010; rd1 = 32'd100; rd2 = 32'd3; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(md_busy), 64'd0);
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort lo", 64'(lo_out), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'd0);

        // reset wins over a concurrent start
        md_start = 1'b1; md_op = 3'b000; rd1 = 32'd2; rd2 = 32'd3; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; md_start = 1'b0;
        check("reset beats start", 64'(md_busy), 64'd0);
        @(posedge clk); #1;
        check("reset beats start later", 64'(md_busy), 64'd0);

        run8(3'b000, 8'h80, 8'h80, 8'h40, 8'h00, "w8 mult");
        run8(3'b010, 8'h80, 8'hFF, 8'h00, 8'h80, "w8 div ovf");
        run8(3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01, "w8 multu");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/executs_muldiv.md
Name: executs_muldiv

Overview:
- Parametrised multi-cycle multiply/divide execute unit with architectural HI/LO registers.
- Sits beside the single-cycle execute ALU.
- Serves MIPS mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Raises Md_busy so the controller stalls the fetch/decode path while an iterative operation runs.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; must be at least 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Md_start  in  1  one-cycle request; sampled only while in IDLE.
- Md_op  in  3  operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved (no effect).
- Read_data_1  in  WIDTH  rs operand: multiplicand / dividend / mthi-mtlo source.
- Read_data_2  in  WIDTH  rt operand: multiplier / divisor.
- Md_sel  in  1  read select: 0 gives LO (mflo), 1 gives HI (mfhi).
- Md_busy  out  1  high while an iterative operation is in flight.
- Md_done  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
- Md_result  out  WIDTH  combinational read: HI if Md_sel=1, else LO.
- Hi_out  out  WIDTH  HI register.
- Lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high, one clock edge):
  - state=IDLE; HI=LO=0; counter=0.
  - Md_busy=0; Md_done=0.
  - Reset wins over any concurrent Md_start.
  - Reset mid-operation aborts the operation: HI/LO are cleared and no Md_done is produced.
- States: IDLE, CALC, FIX, DONE.
- Md_busy = (state != IDLE). It is registered, so it rises the cycle after start.
- IDLE with Md_start=1:
  - mthi: HI <= Read_data_1 at that edge; stay in IDLE; no Md_done.
  - mtlo: LO <= Read_data_1 at that edge; stay in IDLE; no Md_done.
  - mult/multu/div/divu: latch op and operands; go to CALC; counter=0.
    - Signed ops latch absolute values plus the result sign flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Reserved op: ignored.
- Md_start while state != IDLE: ignored entirely, with no queueing. The controller must hold the instruction until Md_busy falls.
- CALC: exactly WIDTH cycles; counter increments each cycle; leaves CALC when counter = WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1 bit partial remainder.
- FIX: one cycle.
  - Apply two's-complement negation per the sign flags.
  - Write HI/LO at the end of FIX: mult → HI = product[2W-1:W], LO = product[W-1:0]; div → LO = quotient, HI = remainder.
- DONE: one cycle; Md_done=1; return to IDLE next edge. Md_busy is still 1 during DONE.
- Latency: start edge to Md_done high = WIDTH+2 cycles (34 at WIDTH=32).
  - HI/LO are valid from the DONE cycle onward.
  - A new Md_start is accepted in the cycle after DONE.
- Divide by zero (divisor = 0), signed or unsigned:
  - LO = all ones; HI = dividend (raw Read_data_1 value).
  - Full latency still applies; no exception is raised.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Md_result, Hi_out and Lo_out reflect register contents only.
  - mfhi/mflo during Md_busy return the old HI/LO values; the controller must stall the read.
- Arithmetic is width-exact. Negating the most-negative value yields itself; magnitude handling uses a WIDTH+1 bit internal width.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF → Md_done exactly 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; Md_busy high for 34 cycles.
- mult -3 x 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. div -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 2 → LO=3, HI=1.
- divu 5 / 0 → LO=0xFFFFFFFF, HI=5. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Back-to-back sequence:
  - mtlo 0x1234, then mthi 0xABCD in consecutive IDLE cycles → Lo_out=0x1234, Hi_out=0xABCD; Md_busy stays 0; no Md_done.
  - Md_sel toggling → Md_result alternates between 0x1234 and 0xABCD.
- Start div, pulse Md_start (mult) at cycle 5 → ignored; Md_done fires once at cycle 34 with the div result. Assert reset at cycle 10 of another op → next cycle IDLE, HI=LO=0, no Md_done.
- WIDTH=8, CNT_W=4: mult 0x80 x 0x80 → HI=0x40, LO=0x00 after 10 cycles; div 0x80 / 0xFF → LO=0x80, HI=0x00.
